// File: rtl/ntt_bf_pipe_if.sv
// Valid/ready bundle for the forward NTT butterfly.
// master drives operands and out_ready; slave is the butterfly.
interface ntt_bf_pipe_if #(
    parameter int N = 9
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] w;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;

    modport master (
        output in_valid, a, b, w, out_ready,
        input  in_ready, out_valid, x, y, busy
    );

    modport slave (
        input  in_valid, a, b, w, out_ready,
        output in_ready, out_valid, x, y, busy
    );
endinterface

// File: rtl/ntt_bf_pipe.sv
// Three-stage Cooley-Tukey butterfly: x = a + b*w, y = a - b*w (mod Q).
// Single global enable stalls the whole pipe when the output is blocked.
module ntt_bf_pipe #(
    parameter int N = 9,
    parameter int Q = 257
) (
    input  logic          clk,
    input  logic          rst_n,
    ntt_bf_pipe_if.slave  bus
);
    localparam logic [N:0]     QS = (N+1)'(Q);
    localparam logic [N-1:0]   QN = N'(Q);
    localparam logic [2*N-1:0] QP = (2*N)'(Q);

    logic           v1, v2, v3;
    logic [2*N-1:0] p1;
    logic [N-1:0]   a1, a2, t2;
    logic [N-1:0]   x3, y3;
    logic           en, take;
    logic [N:0]     s;
    logic [N-1:0]   t_red, x_nxt, y_nxt;

    assign en           = ~v3 | bus.out_ready;
    assign bus.in_ready = en & rst_n;
    assign take         = bus.in_valid & bus.in_ready;

    always_comb begin
        t_red = N'(p1 % QP);
        s     = {1'b0, a2} + {1'b0, t2};
        x_nxt = (s >= QS) ? N'(s - QS) : N'(s);
        // a + Q - t may wrap past 2^N; the final value is still < Q
        y_nxt = (a2 < t2) ? (a2 + QN - t2) : (a2 - t2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            p1 <= '0;
            a1 <= '0;
            a2 <= '0;
            t2 <= '0;
            x3 <= '0;
            y3 <= '0;
        end else if (en) begin
            v1 <= take;
            v2 <= v1;
            v3 <= v2;
            if (take) begin
                p1 <= (2*N)'(bus.b) * (2*N)'(bus.w);
                a1 <= bus.a;
            end
            if (v1) begin
                t2 <= t_red;
                a2 <= a1;
            end
            if (v2) begin
                x3 <= x_nxt;
                y3 <= y_nxt;
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.x         = x3;
    assign bus.y         = y3;
    assign bus.busy      = v1 | v2 | v3;
endmodule
